// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word requests to instruction memory, buffers
// returned words with their PCs, and hands one instruction per cycle to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8002_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        w_stall,
   input  logic        w_redirect,
   input  logic [31:0] w_redirect_pc_32,
   output logic        w_imem_req,
   output logic [31:0] w_imem_addr_32,
   input  logic        w_imem_ready,
   input  logic        w_imem_valid,
   input  logic [31:0] w_imem_data_32,
   output logic        w_valid,
   output logic [31:0] w_instr_32,
   output logic [31:0] w_pc_32
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = CW + 1;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_out_pc;
   logic [31:0]   r_queue [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_in_flight;
   logic [CW-1:0] r_drop_cnt;

   logic          w_pop;
   logic          w_accept;
   logic          w_resp;
   logic          w_push;
   logic          w_drop;
   logic [SW-1:0] w_pending;
   logic [31:0]   w_target_pc;
   logic          w_unused_pc_lsbs;

   assign w_target_pc      = {w_redirect_pc_32[31:2], 2'b00};
   assign w_unused_pc_lsbs = ^w_redirect_pc_32[1:0];

   // NOTE: every signal driven here gets a default first, so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      w_valid        = (r_count != '0);
      w_pop          = w_valid && !w_stall && !w_redirect;
      w_pending      = SW'(r_in_flight) + SW'(r_count) - SW'(w_pop);
      w_imem_req     = !reset && !w_redirect && (w_pending < SW'(DEPTH));
      w_imem_addr_32 = r_fetch_pc;
      w_accept       = w_imem_req && w_imem_ready;
      // A response with nothing outstanding is a protocol error and is ignored.
      w_resp         = w_imem_valid && (r_in_flight != '0);
      w_drop         = w_resp && (r_drop_cnt != '0);
      w_push         = w_resp && (r_drop_cnt == '0) && !w_redirect;
      w_instr_32     = w_valid ? r_queue[r_rd_ptr] : 32'h0000_0000;
      w_pc_32        = r_out_pc;
   end

   // NOTE: state uses non-blocking assignments so every register in this block
   // sees the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_pc  <= RESET_PC;
         r_out_pc    <= RESET_PC;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_in_flight <= '0;
         r_drop_cnt  <= '0;
      end else if (w_redirect) begin
         // No request is issued this cycle, so only a response can change in_flight.
         r_fetch_pc  <= w_target_pc;
         r_out_pc    <= w_target_pc;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_in_flight <= r_in_flight - CW'(w_resp);
         r_drop_cnt  <= r_in_flight - CW'(w_resp);
      end else begin
         if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_out_pc <= r_out_pc + 32'd4;
         end
         r_in_flight <= r_in_flight + CW'(w_accept) - CW'(w_resp);
         r_drop_cnt  <= r_drop_cnt - CW'(w_drop);
         r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // NOTE: the queue storage has no reset; an entry is only read after it has been
   // written, because w_valid comes from the occupancy count, which is reset.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_queue[r_wr_ptr] <= w_imem_data_32;
      end
   end

endmodule
